// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares the single-port data memory between the CPU load/store path and the
//   program loader / DMA engine. Round-robin arbitration, one memory strobe per
//   transaction, fixed memory latency, one-cycle ack pulse per completed access.
// Ports
//   clk, reset_cycle                  clock (rising edge), async active-high reset
//   cpu_req/we/addr/wdata             CPU request, held stable until cpu_ack
//   cpu_ack, cpu_rdata                CPU completion pulse, last CPU read data
//   dma_req/we/addr/wdata             DMA request, same rules as CPU
//   dma_ack, dma_rdata                DMA completion pulse, last DMA read data
//   mem_en, mem_we, mem_addr,
//   mem_wdata, mem_rdata              memory array interface
//   grant_cpu, grant_dma              current owner (ACCESS..DONE)
//   busy                              transaction in progress
module dmem_port_arbiter #(
  parameter int unsigned AW      = 8,
  parameter int unsigned DW      = 8,
  parameter int unsigned MEM_LAT = 1   // legal range 1..15
) (
  input  logic          clk,
  input  logic          reset_cycle,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_ack,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          grant_cpu,
  output logic          grant_dma,
  output logic          busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StWait, StDone} state_e;

  localparam logic [3:0] LatInit = 4'(MEM_LAT - 1);

  state_e        state_q, state_d;
  logic          last_dma_q, last_dma_d;   // 1: DMA won the previous arbitration
  logic          grant_cpu_q, grant_cpu_d;
  logic          grant_dma_q, grant_dma_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]    lat_cnt_q, lat_cnt_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] dma_rdata_q, dma_rdata_d;
  logic          pick_dma;

  // With both requesting, the port that did not win last time goes next.
  assign pick_dma = dma_req & (~cpu_req | ~last_dma_q);

  always_comb begin
    state_d     = state_q;
    last_dma_d  = last_dma_q;
    grant_cpu_d = grant_cpu_q;
    grant_dma_d = grant_dma_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    lat_cnt_d   = lat_cnt_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (cpu_req || dma_req) begin
          state_d     = StAccess;
          last_dma_d  = pick_dma;
          grant_dma_d = pick_dma;
          grant_cpu_d = ~pick_dma;
          mem_we_d    = pick_dma ? dma_we    : cpu_we;
          mem_addr_d  = pick_dma ? dma_addr  : cpu_addr;
          mem_wdata_d = pick_dma ? dma_wdata : cpu_wdata;
        end
      end
      StAccess: begin
        lat_cnt_d = LatInit;
        state_d   = StWait;
      end
      StWait: begin
        if (lat_cnt_q == 4'd0) begin
          if (!mem_we_q) begin
            if (grant_cpu_q) cpu_rdata_d = mem_rdata;
            if (grant_dma_q) dma_rdata_d = mem_rdata;
          end
          state_d = StDone;
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end
      StDone: begin
        grant_cpu_d = 1'b0;
        grant_dma_d = 1'b0;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset_cycle) begin
    if (reset_cycle) begin
      state_q     <= StIdle;
      last_dma_q  <= 1'b1;
      grant_cpu_q <= 1'b0;
      grant_dma_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      lat_cnt_q   <= 4'd0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_dma_q  <= last_dma_d;
      grant_cpu_q <= grant_cpu_d;
      grant_dma_q <= grant_dma_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      lat_cnt_q   <= lat_cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  // Strobes and acks decode from state so an async reset drops them at once.
  assign mem_en    = (state_q == StAccess);
  assign mem_we    = mem_en & mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_ack   = (state_q == StDone) & grant_cpu_q;
  assign dma_ack   = (state_q == StDone) & grant_dma_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign grant_cpu = grant_cpu_q;
  assign grant_dma = grant_dma_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter
//   Directed bench for dmem_port_arbiter. One instance at MEM_LAT=1, one at
//   MEM_LAT=3. Inputs change and outputs are sampled 1 time unit after a rising
//   edge; the memory read data is driven by hand in the cycle it must be valid.
module tb_dmem_port_arbiter;

  logic       clk;
  logic       reset_cycle;

  // MEM_LAT = 1 instance
  logic       c_req, c_we, d_req, d_we;
  logic [7:0] c_addr, c_wdata, d_addr, d_wdata, m_rdata;
  logic       cpu_ack, dma_ack, mem_en, mem_we, grant_cpu, grant_dma, busy;
  logic [7:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;

  // MEM_LAT = 3 instance
  logic       l_c_req, l_c_we, l_d_req, l_d_we;
  logic [7:0] l_c_addr, l_c_wdata, l_d_addr, l_d_wdata, l_m_rdata;
  logic       l_cpu_ack, l_dma_ack, l_mem_en, l_mem_we, l_grant_cpu, l_grant_dma, l_busy;
  logic [7:0] l_cpu_rdata, l_dma_rdata, l_mem_addr, l_mem_wdata;

  int vec_cnt = 0;
  int err_cnt = 0;

  dmem_port_arbiter #(.AW(8), .DW(8), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .reset_cycle(reset_cycle),
    .cpu_req(c_req), .cpu_we(c_we), .cpu_addr(c_addr), .cpu_wdata(c_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(d_req), .dma_we(d_we), .dma_addr(d_addr), .dma_wdata(d_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(m_rdata),
    .grant_cpu(grant_cpu), .grant_dma(grant_dma), .busy(busy)
  );

  dmem_port_arbiter #(.AW(8), .DW(8), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .reset_cycle(reset_cycle),
    .cpu_req(l_c_req), .cpu_we(l_c_we), .cpu_addr(l_c_addr), .cpu_wdata(l_c_wdata),
    .cpu_ack(l_cpu_ack), .cpu_rdata(l_cpu_rdata),
    .dma_req(l_d_req), .dma_we(l_d_we), .dma_addr(l_d_addr), .dma_wdata(l_d_wdata),
    .dma_ack(l_dma_ack), .dma_rdata(l_dma_rdata),
    .mem_en(l_mem_en), .mem_we(l_mem_we), .mem_addr(l_mem_addr), .mem_wdata(l_mem_wdata),
    .mem_rdata(l_m_rdata),
    .grant_cpu(l_grant_cpu), .grant_dma(l_grant_dma), .busy(l_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_cycle = 1'b1;
    tick();
    tick();
    vec_cnt++;
    if ({cpu_ack, dma_ack, mem_en, mem_we, grant_cpu, grant_dma, busy} !== 7'b0) begin
      err_cnt++;
      $display("FAIL reset_ctrl got %b want 0000000",
               {cpu_ack, dma_ack, mem_en, mem_we, grant_cpu, grant_dma, busy});
    end
    vec_cnt++;
    if ({cpu_rdata, dma_rdata, mem_addr, mem_wdata} !== 32'h0) begin
      err_cnt++;
      $display("FAIL reset_data got %h want 00000000",
               {cpu_rdata, dma_rdata, mem_addr, mem_wdata});
    end
    vec_cnt++;
    if ({l_busy, l_mem_en, l_cpu_rdata} !== 10'h0) begin
      err_cnt++;
      $display("FAIL reset_lat3 got %h want 000", {l_busy, l_mem_en, l_cpu_rdata});
    end
    #2 reset_cycle = 1'b0;
    tick();
  endtask

  // T1: CPU read of 0x1F, memory answers 0xA5 in cycle R+2
  task automatic test_cpu_read();
    c_req = 1'b1; c_we = 1'b0; c_addr = 8'h1F; m_rdata = 8'h00;
    tick();  // R+1
    vec_cnt++;
    if ({mem_en, mem_we, mem_addr, grant_cpu, grant_dma} !== {2'b10, 8'h1F, 2'b10}) begin
      err_cnt++;
      $display("FAIL t1_access got en=%b we=%b addr=%h gc=%b gd=%b want 1 0 1f 1 0",
               mem_en, mem_we, mem_addr, grant_cpu, grant_dma);
    end
    tick();  // R+2
    m_rdata = 8'hA5;
    vec_cnt++;
    if ({mem_en, cpu_ack, busy} !== 3'b001) begin
      err_cnt++;
      $display("FAIL t1_wait got en=%b ack=%b busy=%b want 0 0 1", mem_en, cpu_ack, busy);
    end
    tick();  // R+3
    vec_cnt++;
    if ({cpu_ack, dma_ack, cpu_rdata} !== {2'b10, 8'hA5}) begin
      err_cnt++;
      $display("FAIL t1_ack got cack=%b dack=%b rdata=%h want 1 0 a5",
               cpu_ack, dma_ack, cpu_rdata);
    end
    c_req = 1'b0; m_rdata = 8'h00;
    tick();  // R+4
    vec_cnt++;
    if ({cpu_ack, busy, cpu_rdata} !== {2'b00, 8'hA5}) begin
      err_cnt++;
      $display("FAIL t1_after got ack=%b busy=%b rdata=%h want 0 0 a5",
               cpu_ack, busy, cpu_rdata);
    end
  endtask

  // T2: DMA write 0x40 <= 0x3C; read-data registers must not move
  task automatic test_dma_write();
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h40; d_wdata = 8'h3C; m_rdata = 8'h77;
    tick();  // R+1
    vec_cnt++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, grant_dma} !== {2'b11, 8'h40, 8'h3C, 1'b1}) begin
      err_cnt++;
      $display("FAIL t2_access got en=%b we=%b addr=%h wdata=%h gd=%b want 1 1 40 3c 1",
               mem_en, mem_we, mem_addr, mem_wdata, grant_dma);
    end
    tick();  // R+2
    tick();  // R+3
    vec_cnt++;
    if ({dma_ack, cpu_ack, cpu_rdata, dma_rdata} !== {2'b10, 8'hA5, 8'h00}) begin
      err_cnt++;
      $display("FAIL t2_ack got dack=%b cack=%b crd=%h drd=%h want 1 0 a5 00",
               dma_ack, cpu_ack, cpu_rdata, dma_rdata);
    end
    d_req = 1'b0; d_we = 1'b0; m_rdata = 8'h00;
    tick();  // R+4
  endtask

  // T3: both ports request from reset; CPU first, then alternate, 4 cycles apart
  task automatic test_round_robin();
    logic exp_cack, exp_dack, exp_gc, exp_gd, exp_busy;
    reset_cycle = 1'b1;
    #2 reset_cycle = 1'b0;
    c_req = 1'b1; c_we = 1'b0; c_addr = 8'h01;
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h02;
    m_rdata = 8'h11;
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp_cack = (k == 3) || (k == 11);
      exp_dack = (k == 7) || (k == 15);
      exp_gc   = (k >= 1 && k <= 3) || (k >= 9 && k <= 11);
      exp_gd   = (k >= 5 && k <= 7) || (k >= 13 && k <= 15);
      exp_busy = (k % 4) != 0;
      vec_cnt++;
      if ({cpu_ack, dma_ack, grant_cpu, grant_dma, busy} !==
          {exp_cack, exp_dack, exp_gc, exp_gd, exp_busy}) begin
        err_cnt++;
        $display("FAIL t3_cycle%0d got cack=%b dack=%b gc=%b gd=%b busy=%b want %b %b %b %b %b",
                 k, cpu_ack, dma_ack, grant_cpu, grant_dma, busy,
                 exp_cack, exp_dack, exp_gc, exp_gd, exp_busy);
      end
      if (k == 15) begin
        c_req = 1'b0; d_req = 1'b0;
      end
    end
    m_rdata = 8'h00;
    tick();
    vec_cnt++;
    if ({busy, cpu_rdata, dma_rdata} !== {1'b0, 8'h11, 8'h11}) begin
      err_cnt++;
      $display("FAIL t3_end got busy=%b crd=%h drd=%h want 0 11 11", busy, cpu_rdata, dma_rdata);
    end
  endtask

  // T4: MEM_LAT=3, data valid only in R+4, ack in R+5
  task automatic test_lat3();
    l_c_req = 1'b1; l_c_we = 1'b0; l_c_addr = 8'h22; l_m_rdata = 8'hEE;
    tick();  // R+1
    vec_cnt++;
    if ({l_mem_en, l_mem_addr} !== {1'b1, 8'h22}) begin
      err_cnt++;
      $display("FAIL t4_access got en=%b addr=%h want 1 22", l_mem_en, l_mem_addr);
    end
    tick();  // R+2
    tick();  // R+3
    tick();  // R+4
    l_m_rdata = 8'h5A;
    vec_cnt++;
    if ({l_cpu_ack, l_mem_en, l_cpu_rdata} !== {2'b00, 8'h00}) begin
      err_cnt++;
      $display("FAIL t4_r4 got ack=%b en=%b rdata=%h want 0 0 00",
               l_cpu_ack, l_mem_en, l_cpu_rdata);
    end
    tick();  // R+5
    vec_cnt++;
    if ({l_cpu_ack, l_cpu_rdata} !== {1'b1, 8'h5A}) begin
      err_cnt++;
      $display("FAIL t4_ack got ack=%b rdata=%h want 1 5a", l_cpu_ack, l_cpu_rdata);
    end
    l_c_req = 1'b0; l_m_rdata = 8'hEE;
    tick();  // R+6
    vec_cnt++;
    if ({l_cpu_ack, l_busy} !== 2'b00) begin
      err_cnt++;
      $display("FAIL t4_after got ack=%b busy=%b want 0 0", l_cpu_ack, l_busy);
    end
  endtask

  // T5: reset pulsed in WAIT; transaction discarded, next one nominal
  task automatic test_reset_mid();
    int acks;
    c_req = 1'b1; c_we = 1'b0; c_addr = 8'h10; m_rdata = 8'h99;
    tick();  // R+1
    tick();  // R+2 (WAIT)
    #2 reset_cycle = 1'b1;
    #1;
    vec_cnt++;
    if ({mem_en, cpu_ack, dma_ack, grant_cpu, grant_dma, busy, cpu_rdata} !== {6'b0, 8'h00}) begin
      err_cnt++;
      $display("FAIL t5_async got en=%b ca=%b da=%b gc=%b gd=%b busy=%b rd=%h want all 0",
               mem_en, cpu_ack, dma_ack, grant_cpu, grant_dma, busy, cpu_rdata);
    end
    c_req = 1'b0;
    #2 reset_cycle = 1'b0;
    acks = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (cpu_ack || dma_ack || mem_en) acks++;
    end
    vec_cnt++;
    if (acks !== 0) begin
      err_cnt++;
      $display("FAIL t5_no_ack got %0d active cycles want 0", acks);
    end
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h05; m_rdata = 8'h3D;
    tick();  // R+1
    vec_cnt++;
    if ({mem_en, mem_addr, grant_dma} !== {1'b1, 8'h05, 1'b1}) begin
      err_cnt++;
      $display("FAIL t5_access got en=%b addr=%h gd=%b want 1 05 1", mem_en, mem_addr, grant_dma);
    end
    tick();  // R+2
    tick();  // R+3
    vec_cnt++;
    if ({dma_ack, dma_rdata} !== {1'b1, 8'h3D}) begin
      err_cnt++;
      $display("FAIL t5_ack got ack=%b rdata=%h want 1 3d", dma_ack, dma_rdata);
    end
    d_req = 1'b0; m_rdata = 8'h00;
    tick();
  endtask

  // T6: CPU drops req in the cycle after ACCESS; one access, one ack
  task automatic test_drop_req();
    int ens;
    int acks;
    ens = 0;
    acks = 0;
    c_req = 1'b1; c_we = 1'b0; c_addr = 8'h33; m_rdata = 8'h6B;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 2) c_req = 1'b0;
      if (mem_en) ens++;
      if (cpu_ack) acks++;
      if (k == 3) begin
        vec_cnt++;
        if (cpu_ack !== 1'b1) begin
          err_cnt++;
          $display("FAIL t6_ack_time got %b want 1", cpu_ack);
        end
      end
    end
    vec_cnt++;
    if ({ens, acks} !== {32'd1, 32'd1}) begin
      err_cnt++;
      $display("FAIL t6_counts got en=%0d ack=%0d want 1 1", ens, acks);
    end
    vec_cnt++;
    if ({busy, cpu_rdata} !== {1'b0, 8'h6B}) begin
      err_cnt++;
      $display("FAIL t6_end got busy=%b rdata=%h want 0 6b", busy, cpu_rdata);
    end
    m_rdata = 8'h00;
  endtask

  initial begin
    reset_cycle = 1'b0;
    c_req = 1'b0; c_we = 1'b0; c_addr = 8'h00; c_wdata = 8'h00;
    d_req = 1'b0; d_we = 1'b0; d_addr = 8'h00; d_wdata = 8'h00; m_rdata = 8'h00;
    l_c_req = 1'b0; l_c_we = 1'b0; l_c_addr = 8'h00; l_c_wdata = 8'h00;
    l_d_req = 1'b0; l_d_we = 1'b0; l_d_addr = 8'h00; l_d_wdata = 8'h00; l_m_rdata = 8'h00;
    #1;
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_round_robin();
    test_lat3();
    test_reset_mid();
    test_drop_req();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
